// File: rtl/ex_btc_bilin_blend_pkg.sv
// ex_btc_bilin_blend_pkg: shared state encodings and texel order for the bilinear blend stage
package ex_btc_bilin_blend_pkg;
  typedef enum logic [1:0] {BLN_IDLE = 2'd0, BLN_ACC = 2'd1, BLN_OUT = 2'd2} bln_state_e;
  localparam logic [1:0] TEX_00 = 2'd0;
  localparam logic [1:0] TEX_10 = 2'd1;
  localparam logic [1:0] TEX_01 = 2'd2;
  localparam logic [1:0] TEX_11 = 2'd3;
  localparam int CH_W = 16;
  localparam int N_CH = 4;
endpackage

// File: rtl/ex_btc_bilin_mac.sv
// ex_btc_bilin_mac: one channel's texel-times-weight product added onto its running accumulator
module ex_btc_bilin_mac import ex_btc_bilin_blend_pkg::*; #(
  parameter int WW = 9,
  parameter int AW = 25
) (
  input  logic [CH_W-1:0] tex,
  input  logic [WW-1:0]   w,
  input  logic [AW-1:0]   acc_i,
  output logic [AW-1:0]   acc_o
);
  assign acc_o = acc_i + AW'(tex) * AW'(w);
endmodule

// File: rtl/ex_btc_bilin_blend.sv
// ex_btc_bilin_blend: collects a 2x2 texel footprint and emits its bilinear (or point) filtered texel
module ex_btc_bilin_blend import ex_btc_bilin_blend_pkg::*; #(
  parameter int FRAC_BITS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmdValid,
  output logic                 cmdReady,
  input  logic [FRAC_BITS-1:0] cmdFracU,
  input  logic [FRAC_BITS-1:0] cmdFracV,
  input  logic                 cmdPoint,
  input  logic                 texValid,
  output logic                 texReady,
  input  logic [63:0]          texVal,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [63:0]          outVal
);
  localparam int WW = 2*FRAC_BITS+1;
  localparam int AW = CH_W+WW;
  localparam logic [AW-1:0] BIAS = AW'(1) << (2*FRAC_BITS-1);
  localparam logic [WW-1:0] S = WW'(1) << FRAC_BITS;
  bln_state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [FRAC_BITS-1:0] fu_q, fu_d, fv_q, fv_d;
  logic pt_q, pt_d;
  logic [N_CH-1:0][AW-1:0] acc_q, acc_d, sum;
  logic [63:0] out_q, out_d, blend;
  logic [WW-1:0] fu_x, fv_x, su, sv, w;
  // weight for the texel about to arrive, selected by its position in the footprint
  always_comb begin
    fu_x = WW'(fu_q);
    fv_x = WW'(fv_q);
    su = S - fu_x;
    sv = S - fv_x;
    w = cnt_q == TEX_00 ? su * sv : cnt_q == TEX_10 ? fu_x * sv : cnt_q == TEX_01 ? su * fv_x : fu_x * fv_x;
  end
  for (genvar c = 0; c < N_CH; c++) begin : g_mac
    ex_btc_bilin_mac #(.WW(WW), .AW(AW)) u_mac (
      .tex  (texVal[CH_W*c +: CH_W]),
      .w    (w),
      .acc_i(acc_q[c]),
      .acc_o(sum[c])
    );
    assign blend[CH_W*c +: CH_W] = sum[c][2*FRAC_BITS +: CH_W];
  end
  // command latch, texel accumulation and result hand-off
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    fu_d = fu_q;
    fv_d = fv_q;
    pt_d = pt_q;
    acc_d = acc_q;
    out_d = out_q;
    if (state_q == BLN_IDLE) begin
      if (cmdValid) begin
        fu_d = cmdFracU;
        fv_d = cmdFracV;
        pt_d = cmdPoint;
        cnt_d = '0;
        acc_d = {N_CH{BIAS}};
        state_d = BLN_ACC;
      end
    end else if (state_q == BLN_ACC) begin
      if (texValid) begin
        acc_d = sum;
        cnt_d = cnt_q + 2'd1;
        if (pt_q || cnt_q == TEX_11) begin
          out_d = pt_q ? texVal : blend;
          state_d = BLN_OUT;
        end
      end
    end else if (outReady) begin
      state_d = BLN_IDLE;
    end
  end
  // state registers; reset drops any partial footprint and pending result
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= BLN_IDLE;
      cnt_q <= '0;
      fu_q <= '0;
      fv_q <= '0;
      pt_q <= 1'b0;
      acc_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fu_q <= fu_d;
      fv_q <= fv_d;
      pt_q <= pt_d;
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end
  assign cmdReady = state_q == BLN_IDLE;
  assign texReady = state_q == BLN_ACC;
  assign outValid = state_q == BLN_OUT;
  assign outVal = out_q;
endmodule

// File: tb/tb_ex_btc_bilin_blend.sv
// tb_ex_btc_bilin_blend: randomized and directed checks of the bilinear blend stage against an arithmetic model
module tb_ex_btc_bilin_blend;
  logic clock = 0, reset = 0, cmdValid = 0, cmdReady, cmdPoint = 0;
  logic texValid = 0, texReady, outValid, outReady = 0;
  logic [3:0] cmdFracU = 0, cmdFracV = 0;
  logic [63:0] texVal = 0, outVal;
  logic [63:0] tx [4];
  int pass_cnt = 0, total_cnt = 0;

  ex_btc_bilin_blend #(.FRAC_BITS(4)) dut (
    .clock(clock), .reset(reset),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdFracU(cmdFracU), .cmdFracV(cmdFracV), .cmdPoint(cmdPoint),
    .texValid(texValid), .texReady(texReady), .texVal(texVal),
    .outValid(outValid), .outReady(outReady), .outVal(outVal)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [63:0] model(int fu, int fv, bit pt);
    longint w [4];
    longint s;
    logic [63:0] r;
    if (pt) return tx[0];
    w[0] = (16 - fu) * (16 - fv);
    w[1] = fu * (16 - fv);
    w[2] = (16 - fu) * fv;
    w[3] = fu * fv;
    for (int ch = 0; ch < 4; ch++) begin
      s = 128;
      for (int k = 0; k < 4; k++) s += w[k] * longint'(tx[k][16*ch +: 16]);
      r[16*ch +: 16] = 16'(s >> 8);
    end
    return r;
  endfunction

  task automatic rand_tx();
    for (int k = 0; k < 4; k++) tx[k] = {$urandom, $urandom};
  endtask

  task automatic run_fp(input int fu, input int fv, input bit pt, input int stall, input bit gaps,
                        output logic [63:0] res, output int lat, output int used,
                        output bit stable, output bit hold, output bit to);
    int k = 0;
    int g = 0;
    bit ok;
    logic [6:0] pat = 7'b1011001;
    res = '0; lat = 0; used = 0; stable = 1; hold = 1; to = 0;
    for (int i = 0; i < 20 && !cmdReady; i++) begin @(posedge clock); #1; end
    cmdValid = 1; cmdFracU = fu[3:0]; cmdFracV = fv[3:0]; cmdPoint = pt;
    @(posedge clock); #1;
    cmdValid = 0;
    while (!outValid && lat < 40) begin
      texValid = gaps ? (g < 7 ? pat[g] : 1'b1) : 1'b1;
      texVal = tx[k & 3];
      ok = texValid && texReady;
      @(posedge clock); #1;
      lat++; g++;
      if (ok) begin used++; k++; end
    end
    texValid = 0;
    if (!outValid) begin to = 1; return; end
    res = outVal;
    if (cmdReady) hold = 0;
    for (int i = 0; i < stall; i++) begin
      @(posedge clock); #1;
      if (outVal !== res || !outValid) stable = 0;
      if (cmdReady) hold = 0;
    end
    outReady = 1;
    @(posedge clock); #1;
    outReady = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    @(posedge clock); #1;
    total_cnt++; if (cmdReady !== 1'b1) $display("FAIL reset_cmdReady: got %b want 1", cmdReady); else pass_cnt++;
    total_cnt++; if (texReady !== 1'b0) $display("FAIL reset_texReady: got %b want 0", texReady); else pass_cnt++;
    total_cnt++; if (outValid !== 1'b0) $display("FAIL reset_outValid: got %b want 0", outValid); else pass_cnt++;
    total_cnt++; if (outVal !== 64'h0) $display("FAIL reset_outVal: got %h want 0", outVal); else pass_cnt++;
    reset = 0;
    @(posedge clock); #1;
  endtask

  task automatic test_equal();
    logic [63:0] r; int lat, used; bit st, hd, to;
    for (int k = 0; k < 4; k++) tx[k] = 64'h1234_5678_9ABC_DEF0;
    run_fp(5, 9, 0, 0, 0, r, lat, used, st, hd, to);
    total_cnt++; if (to || r !== 64'h1234_5678_9ABC_DEF0) $display("FAIL equal_val: got %h want 123456789abcdef0 (timeout %0d)", r, to); else pass_cnt++;
    total_cnt++; if (lat !== 4) $display("FAIL equal_latency: got %0d want 4", lat); else pass_cnt++;
    total_cnt++; if (outValid !== 1'b0 || cmdReady !== 1'b1) $display("FAIL equal_release: got outValid %b cmdReady %b want 0 1", outValid, cmdReady); else pass_cnt++;
  endtask

  task automatic test_zero_frac();
    logic [63:0] r; int lat, used; bit st, hd, to;
    tx[0] = 64'hFFFF_0000_8080_0101; tx[1] = 0; tx[2] = 0; tx[3] = 0;
    run_fp(0, 0, 0, 0, 0, r, lat, used, st, hd, to);
    total_cnt++; if (to || r !== 64'hFFFF_0000_8080_0101) $display("FAIL zero_frac: got %h want ffff000080800101", r); else pass_cnt++;
    tx[0] = 0; tx[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    run_fp(15, 15, 0, 0, 0, r, lat, used, st, hd, to);
    total_cnt++; if (to || r !== 64'hE0FF_E0FF_E0FF_E0FF) $display("FAIL max_frac: got %h want e0ffe0ffe0ffe0ff", r); else pass_cnt++;
  endtask

  task automatic test_mixed();
    logic [63:0] r; int lat, used; bit st, hd, to;
    tx[0] = 0; tx[1] = 64'h0000_FFFF_0000_0000; tx[2] = 0; tx[3] = 0;
    run_fp(8, 0, 0, 0, 0, r, lat, used, st, hd, to);
    total_cnt++; if (to || r !== 64'h0000_8000_0000_0000) $display("FAIL mixed: got %h want 0000800000000000", r); else pass_cnt++;
  endtask

  task automatic test_point_stall();
    logic [63:0] r; int lat, used; bit st, hd, to;
    tx[0] = 64'hAAAA_BBBB_CCCC_DDDD; tx[1] = 64'h1111_1111_1111_1111; tx[2] = 0; tx[3] = 0;
    run_fp(7, 3, 1, 5, 0, r, lat, used, st, hd, to);
    total_cnt++; if (to || r !== 64'hAAAA_BBBB_CCCC_DDDD) $display("FAIL point_val: got %h want aaaabbbbccccdddd", r); else pass_cnt++;
    total_cnt++; if (lat !== 1 || used !== 1) $display("FAIL point_latency: got lat %0d used %0d want 1 1", lat, used); else pass_cnt++;
    total_cnt++; if (st !== 1'b1) $display("FAIL point_stable: got %b want 1", st); else pass_cnt++;
    total_cnt++; if (hd !== 1'b1) $display("FAIL point_cmdReady_low: got %b want 1", hd); else pass_cnt++;
    total_cnt++; if (cmdReady !== 1'b1) $display("FAIL point_next_cmd: got cmdReady %b want 1", cmdReady); else pass_cnt++;
  endtask

  task automatic test_gaps();
    logic [63:0] r1, r2, e; int lat, used; bit st, hd, to;
    rand_tx();
    e = model(6, 10, 0);
    run_fp(6, 10, 0, 0, 1, r1, lat, used, st, hd, to);
    total_cnt++; if (to || r1 !== e) $display("FAIL gaps_val: got %h want %h", r1, e); else pass_cnt++;
    total_cnt++; if (used !== 4) $display("FAIL gaps_used: got %0d want 4", used); else pass_cnt++;
    run_fp(6, 10, 0, 0, 0, r2, lat, used, st, hd, to);
    total_cnt++; if (to || r2 !== r1) $display("FAIL gaps_vs_b2b: got %h want %h", r2, r1); else pass_cnt++;
  endtask

  task automatic test_back_to_back(input bit pt);
    int n = 0;
    int k = 0;
    logic [63:0] e;
    rand_tx();
    e = model(3, 11, pt);
    cmdValid = 1; cmdFracU = 4'd3; cmdFracV = 4'd11; cmdPoint = pt;
    texValid = 1; outReady = 1;
    for (int i = 0; i < 60; i++) begin
      texVal = tx[k];
      if (texReady) k = pt ? 0 : (k + 1) % 4;
      if (outValid) begin
        n++;
        total_cnt++; if (outVal !== e) $display("FAIL b2b_val pt=%0d: got %h want %h", pt, outVal, e); else pass_cnt++;
      end
      @(posedge clock); #1;
    end
    cmdValid = 0; texValid = 0; outReady = 0;
    total_cnt++; if (n !== (pt ? 20 : 10)) $display("FAIL b2b_rate pt=%0d: got %0d want %0d", pt, n, pt ? 20 : 10); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [63:0] r, e; int lat, used, fu, fv; bit st, hd, to, pt;
    for (int it = 0; it < 12; it++) begin
      rand_tx();
      fu = $urandom_range(0, 15); fv = $urandom_range(0, 15); pt = 1'($urandom_range(0, 3) == 0);
      e = model(fu, fv, pt);
      run_fp(fu, fv, pt, $urandom_range(0, 3), 0, r, lat, used, st, hd, to);
      total_cnt++; if (to || r !== e || lat !== (pt ? 1 : 4)) $display("FAIL random fu=%0d fv=%0d pt=%0d: got %h lat %0d want %h lat %0d", fu, fv, pt, r, lat, e, pt ? 1 : 4); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] r, e; int lat, used; bit st, hd, to;
    rand_tx();
    cmdValid = 1; cmdFracU = 4'd9; cmdFracV = 4'd2; cmdPoint = 0;
    @(posedge clock); #1;
    cmdValid = 0;
    for (int k = 0; k < 2; k++) begin
      texValid = 1; texVal = tx[k];
      @(posedge clock); #1;
    end
    texValid = 0;
    reset = 1;
    #1;
    total_cnt++; if (cmdReady !== 1'b1 || texReady !== 1'b0 || outValid !== 1'b0 || outVal !== 64'h0)
      $display("FAIL reset_mid: got cmdReady %b texReady %b outValid %b outVal %h want 1 0 0 0", cmdReady, texReady, outValid, outVal); else pass_cnt++;
    @(posedge clock); #1;
    reset = 0;
    @(posedge clock); #1;
    rand_tx();
    e = model(9, 2, 0);
    run_fp(9, 2, 0, 0, 0, r, lat, used, st, hd, to);
    total_cnt++; if (to || r !== e) $display("FAIL reset_mid_next: got %h want %h", r, e); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_equal();
    test_zero_frac();
    test_mixed();
    test_point_stall();
    test_gaps();
    test_back_to_back(0);
    test_back_to_back(1);
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/ex_btc_bilin_blend.md
# ex_btc_bilin_blend

Downstream stage of the UTX1/UTX2/UTX3 texel extractor. It collects the four 64-bit RGBA texels the extractor produces for one bilinear footprint (four 16-bit channels A,R,G,B), weights them by the fractional texture coordinates, and emits one filtered 64-bit RGBA texel. A point-sample mode passes a single texel through unchanged. It sits between the texel extractor's result register and the texture-load writeback path.

## Interface
- FRAC_BITS, 4: width of each fractional coordinate; the weight sum is 2^(2*FRAC_BITS) = 256.
- clock  in  1  Single clock; all state updates on the rising edge.
- reset  in  1  Asynchronous, active-high; clears all state.
- cmdValid  in  1  Command present.
- cmdReady  out  1  Command accepted when cmdValid&&cmdReady.
- cmdFracU  in  FRAC_BITS  Horizontal fraction fu.
- cmdFracV  in  FRAC_BITS  Vertical fraction fv.
- cmdPoint  in  1  1 = point sample: consume one texel and forward it unchanged.
- texValid  in  1  Texel present.
- texReady  out  1  Texel accepted when texValid&&texReady.
- texVal  in  64  Texel {A,R,G,B}, 16 bits per channel.
- outValid  out  1  Filtered texel valid.
- outReady  in  1  Consumer accepts when outValid&&outReady.
- outVal  out  64  Filtered texel {A,R,G,B}.

## Operation
- States:
  - IDLE: cmdReady=1; accepting a command latches fu, fv and point, clears the accumulators and count, then moves to ACC.
  - ACC: texReady=1; each accepted texel increments the 2-bit count.
  - OUT: outValid=1.
- Texel order is fixed: T00 (u0,v0), T10 (u1,v0), T01 (u0,v1), T11 (u1,v1).
- Weights, with S = 2^FRAC_BITS = 16, each 9 bits:
  - w00 = (S-fu)(S-fv)
  - w10 = fu(S-fv)
  - w01 = (S-fu)fv
  - w11 = fu·fv
  - The weights always sum to 256.
- Per channel, each accepted texel adds 16b × 9b into a 25-bit accumulator initialised to 128 (rounding bias). Final channel value = acc[23:8]. The maximum is 65535·256+128, which fits in 25 bits, so there is no overflow and no saturation.
- ACC → OUT:
  - Bilinear mode: on acceptance of the 4th texel (count==3).
  - Point mode: on acceptance of the 1st texel. outVal is latched from texVal verbatim, with no arithmetic.
- OUT → IDLE on outValid&&outReady. outVal holds stable while outValid=1 and outReady=0.
- A texel is accepted only in ACC. A command is accepted only in IDLE, so texels and commands never overlap.
- If all four texels are equal, the output equals that texel exactly. fu=fv=0 gives T00 exactly. fu=fv=15 weights T11 by 225/256.

## Timing
- Reset values: cmdReady=1, texReady=0, outValid=0, outVal=0. State is IDLE, count=0, accumulators=0.
- Reset asserted mid-operation discards the partial footprint and any pending output immediately.
- Latency:
  - Bilinear: command accept at cycle c, texels accepted at c+1..c+4 back-to-back, outValid at c+5.
  - Point: command at c, texel at c+1, outValid at c+2.
- Throughput:
  - One bilinear result per 6 cycles with outReady held high: the IDLE cycle for the command, 4 texel cycles, and the OUT cycle.
  - One point result per 3 cycles.
- All ready/valid outputs are driven from registered state only. There is no combinational path from any *Valid input to any *Ready output.
- Texel gaps (texValid=0) stall ACC indefinitely with count and accumulators held.
- Output stall (outReady=0) holds OUT. cmdReady=0 during the stall.

## Structure
- The shared package (the team's jx2 defines header) holds:
  - the state encodings BLN_IDLE=2'd0, BLN_ACC=2'd1, BLN_OUT=2'd2;
  - the texel order constants.
- One sub-module, ex_btc_bilin_mac: one channel's combinational 16×9 multiply plus 25-bit add. It is instantiated four times (A,R,G,B).
- Weight selection is a 4-way mux on count, in the parent.

## Test plan
- Equal texels: fu=5, fv=9, four texels 0x1234_5678_9ABC_DEF0 → outVal 0x1234_5678_9ABC_DEF0 at cycle c+5.
- Zero fractions: fu=fv=0, T00 = 0xFFFF_0000_8080_0101, other texels 0 → outVal equals T00.
- Mixed weights: fu=8, fv=0, T00 R=0x0000, T10 R=0xFFFF, all other channels 0 → R=0x8000 (acc=65535·128+128=0x800000, so acc[23:8]=0x8000); A, G and B are 0.
- Point mode, output stall: cmdPoint=1, texel 0xAAAA_BBBB_CCCC_DDDD, outReady=0 for 5 cycles → outVal held stable, cmdReady=0 throughout; the next command is accepted the cycle after the handshake.
- Texel gaps: texValid toggling 1,0,0,1,1,0,1 → exactly 4 texels consumed, result identical to the back-to-back case.
- Reset mid-ACC after 2 texels: all outputs return to reset values immediately, and the next full command produces a result uncontaminated by the partial accumulation.
